// File: rtl/kmerge_run_ptr_gen.sv
// Run pointer generator for the 8-way k-merge core: loads per-way run bases for each
// group, clips them to the array length, then serves pops with one registered read address each.
module kmerge_run_ptr_gen #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned LEN_W  = 17,
   parameter int unsigned WAYS   = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  run_len,
   input  logic [ADDR_W-1:0] total_len,
   input  logic [7:0]        n_groups,
   input  logic              base_valid,
   input  logic [ADDR_W-1:0] base_data,
   output logic              base_ready,
   input  logic              pop_valid,
   input  logic [2:0]        pop_way,
   output logic              pop_ready,
   output logic              rd_addr_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [WAYS-1:0]   way_empty,
   output logic              group_done,
   output logic              pass_done,
   output logic              busy,
   output logic              err
);

   localparam int unsigned EW = ADDR_W + 1;

   typedef enum logic [1:0] {StIdle, StLoad, StServe, StGdone} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  run_len_q, run_len_d;
   logic [ADDR_W-1:0] total_len_q, total_len_d;
   logic [7:0]        n_groups_q, n_groups_d;
   logic [7:0]        grp_cnt_q, grp_cnt_d;
   logic [2:0]        k_q, k_d;
   logic [ADDR_W-1:0] head_q [WAYS];
   logic [ADDR_W-1:0] head_d [WAYS];
   logic [EW-1:0]     end_q  [WAYS];
   logic [EW-1:0]     end_d  [WAYS];
   logic [WAYS-1:0]   empty_q, empty_d;
   logic              err_q, err_d;
   logic              zero_pass_q, zero_pass_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   // Base classification, evaluated against the values latched at start
   logic [EW-1:0] base_ext, total_ext, base_sum, end_new;
   logic          base_neg, base_oob;

   assign base_ext  = {1'b0, base_data};
   assign total_ext = {1'b0, total_len_q};
   assign base_sum  = base_ext + EW'(run_len_q);
   assign end_new   = (base_sum > total_ext) ? total_ext : base_sum;
   assign base_neg  = base_data[ADDR_W-1];
   assign base_oob  = base_data >= total_len_q;

   logic          pop_fire;
   logic [EW-1:0] head_inc;

   assign pop_fire = (state_q == StServe) && pop_valid && !empty_q[pop_way];
   assign head_inc = {1'b0, head_q[pop_way]} + EW'(1);

   always_comb begin
      state_d     = state_q;
      run_len_d   = run_len_q;
      total_len_d = total_len_q;
      n_groups_d  = n_groups_q;
      grp_cnt_d   = grp_cnt_q;
      k_d         = k_q;
      head_d      = head_q;
      end_d       = end_q;
      empty_d     = empty_q;
      err_d       = err_q;
      zero_pass_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_addr_d   = rd_addr_q;
      base_ready  = 1'b0;
      pop_ready   = 1'b0;
      group_done  = 1'b0;
      pass_done   = zero_pass_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               run_len_d   = run_len;
               total_len_d = total_len;
               n_groups_d  = n_groups;
               grp_cnt_d   = 8'd0;
               err_d       = 1'b0;
               if (n_groups == 8'd0) begin
                  zero_pass_d = 1'b1;
               end else begin
                  state_d = StLoad;
                  k_d     = 3'd0;
               end
            end
         end

         StLoad: begin
            base_ready = 1'b1;
            if (base_valid) begin
               if (base_neg) begin
                  empty_d[k_q] = 1'b1;
                  err_d        = 1'b1;
               end else if (base_oob) begin
                  empty_d[k_q] = 1'b1;
               end else begin
                  head_d[k_q]  = base_data;
                  end_d[k_q]   = end_new;
                  // a zero-length run has no elements to hand out
                  empty_d[k_q] = (end_new == base_ext);
               end
               k_d = k_q + 3'd1;
               if (k_q == 3'(WAYS - 1)) begin
                  state_d = (&empty_d) ? StGdone : StServe;
               end
            end
         end

         StServe: begin
            pop_ready = pop_fire;
            if (pop_fire) begin
               rd_valid_d      = 1'b1;
               rd_addr_d       = head_q[pop_way];
               head_d[pop_way] = head_inc[ADDR_W-1:0];
               if (head_inc == end_q[pop_way]) begin
                  empty_d[pop_way] = 1'b1;
               end
               if (&empty_d) begin
                  state_d = StGdone;
               end
            end
         end

         StGdone: begin
            group_done = 1'b1;
            grp_cnt_d  = grp_cnt_q + 8'd1;
            if (grp_cnt_d == n_groups_q) begin
               pass_done = 1'b1;
               state_d   = StIdle;
            end else begin
               state_d = StLoad;
               k_d     = 3'd0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= StIdle;
         run_len_q   <= '0;
         total_len_q <= '0;
         n_groups_q  <= '0;
         grp_cnt_q   <= '0;
         k_q         <= '0;
         for (int i = 0; i < WAYS; i++) begin
            head_q[i] <= '0;
            end_q[i]  <= '0;
         end
         empty_q     <= '1;
         err_q       <= 1'b0;
         zero_pass_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         run_len_q   <= run_len_d;
         total_len_q <= total_len_d;
         n_groups_q  <= n_groups_d;
         grp_cnt_q   <= grp_cnt_d;
         k_q         <= k_d;
         for (int i = 0; i < WAYS; i++) begin
            head_q[i] <= head_d[i];
            end_q[i]  <= end_d[i];
         end
         empty_q     <= empty_d;
         err_q       <= err_d;
         zero_pass_q <= zero_pass_d;
         rd_valid_q  <= rd_valid_d;
         rd_addr_q   <= rd_addr_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign err           = err_q;
   assign way_empty     = empty_q;
   assign rd_addr       = rd_addr_q;
   assign rd_addr_valid = rd_valid_q;

endmodule

// File: doc/kmerge_run_ptr_gen.md
Name: kmerge_run_ptr_gen

Overview:
Downstream consumer of the 4-stage 18s x 17ns run-base multiplier in the oct k-merge sorter. For each merge group it collects 8 run base offsets (run_idx*run_len) from the multiplier and derives per-way head/end pointers clipped to the array length. It then serves pop requests from the 8-way merge core with one read address per accepted pop, and sequences groups across one merge pass.

Parameters:
ADDR_W, 18, address/base width; bases arrive as signed values of this width
LEN_W, 17, run length width (unsigned)
WAYS, 8, merge fan-in; fixed at 8 in this design, and pop_way is 3 bits

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse; starts a pass, sampled only in IDLE
run_len  in  LEN_W  run length, latched at start
total_len  in  ADDR_W  array length (unsigned), latched at start
n_groups  in  8  number of groups in this pass, latched at start
base_valid  in  1  multiplier product valid
base_data  in  ADDR_W  signed run base from the multiplier dout
base_ready  out  1  high in LOAD
pop_valid  in  1  merge core requests the next element of a way
pop_way  in  3  way index of the request
pop_ready  out  1  pop accepted this cycle
rd_addr_valid  out  1  registered read strobe
rd_addr  out  ADDR_W  registered read address
way_empty  out  WAYS  per-way exhausted flags
group_done  out  1  one-cycle pulse at the end of each group
pass_done  out  1  one-cycle pulse at the end of the pass
busy  out  1  high whenever state is not IDLE
err  out  1  sticky negative-base flag; cleared by start or reset

Behaviour:
- Reset values: all outputs 0, except way_empty, which resets to all ones. State resets to IDLE, and head/end registers reset to 0.
- Reset is asynchronous and fully aborts any operation in progress, including mid-LOAD or mid-SERVE. No pulses are emitted after reset is released.
- States: IDLE, LOAD, SERVE, GDONE.
- IDLE, start=1: latch run_len, total_len and n_groups; clear the group count and err.
  - If n_groups=0, go to GDONE-free completion: pass_done pulses next cycle and the state stays IDLE.
  - Otherwise go to LOAD, with load index k=0.
- LOAD:
  - base_ready=1. Each base_valid&&base_ready beat writes way k, then k increments.
  - Per-beat classification of the base:
    - base_data<0: way empty and err set.
    - base_data >= total_len: way empty.
    - Otherwise: head[k]=base_data; end[k]=min(base_data+run_len, total_len), computed at ADDR_W+1 bits unsigned; way_empty[k]=0.
  - After the 8th beat: go to SERVE if any way is non-empty, otherwise go to GDONE.
  - Upstream always sends exactly 8 bases per group and pads with total_len.
- SERVE:
  - pop_ready = pop_valid && !way_empty[pop_way]. A pop to an empty way is held off, not dropped.
  - On an accepted pop: rd_addr<=head[w] and rd_addr_valid<=1 on the next cycle (latency 1); head[w]++.
  - If head[w]+1==end[w], set way_empty[w] in the same update.
  - Back-to-back pops are supported at 1 per cycle; rd_addr_valid is 0 in any cycle following no accepted pop.
  - When the accepted pop empties the last non-empty way, go to GDONE.
- GDONE (one cycle):
  - group_done=1 and the group count increments.
  - If the count equals n_groups: pass_done=1 in this same cycle and the state goes to IDLE.
  - Otherwise go to LOAD with k=0.
  - The final rd_addr_valid of the group and the group_done pulse coincide.
- start outside IDLE is ignored. base_valid outside LOAD is ignored, and base_ready is 0 there.
- Width: run_len is zero-extended to ADDR_W+1 before the add; rd_addr never reaches or exceeds end[w].

Test Plan:
1. Full group: run_len=4, total_len=64, n_groups=1, bases 0,4,...,28; pop ways 0..7 round-robin x4 -> 32 rd_addr, e.g. the first 8 are 0,4,...,28; group_done and pass_done pulse together one cycle after the last pop; way_empty=8'hFF.
2. Clipped tail: run_len=10, total_len=25, bases 0,10,20,25,25,25,25,25 -> ways 3..7 empty after LOAD; way 2 yields 20..24 only; pop_ready=0 for pop_way=5.
3. All-empty group plus negative base: bases 8'h.. all =total_len except one 18'h3FFFF -> err=1, SERVE skipped, group_done one cycle after the 8th beat.
4. Multi-group: n_groups=3 -> 3 group_done pulses, a single pass_done coincident with the 3rd; base_ready low during SERVE even with base_valid=1.
5. n_groups=0 -> pass_done one cycle after start, busy stays 0. Separately, start asserted during SERVE -> ignored.
6. Async reset mid-SERVE (ap_rst_n low between clock edges) -> outputs clear immediately, way_empty=8'hFF, state IDLE; a fresh start runs scenario 1 correctly.
